// File: rtl/phy_mgmt_pkg.sv
// -----------------------------------------------------------------------------
// phy_mgmt_pkg
// Shared definitions for the PHY management poller: FSM state encoding, MDIO
// frame field lengths, clause-22 start/opcode codes, PHY status register bit
// positions and speed codes, plus a helper that assembles the 14-bit read
// command (ST, OP, PHYAD, REGAD) shifted out MSB-first.
// -----------------------------------------------------------------------------
package phy_mgmt_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        PRE  = 3'd2,
        CMD  = 3'd3,
        TA   = 3'd4,
        DATA = 3'd5,
        DONE = 3'd6
    } mgmt_state_e;

    localparam int PRE_BITS  = 32;
    localparam int CMD_BITS  = 14;
    localparam int TA_BITS   = 2;
    localparam int DATA_BITS = 16;

    localparam logic [1:0] ST_CODE = 2'b01;
    localparam logic [1:0] OP_READ = 2'b10;

    // PHY-specific status register fields
    localparam int STAT_SPD_HI   = 15;
    localparam int STAT_SPD_LO   = 14;
    localparam int STAT_RESOLVED = 11;
    localparam int STAT_LINK     = 10;

    localparam logic [1:0] SPD_1000 = 2'b10;
    localparam logic [1:0] SPD_100  = 2'b01;
    localparam logic [1:0] SPD_10   = 2'b00;

    function automatic logic [CMD_BITS-1:0] read_cmd(input logic [4:0] phy_addr,
                                                     input logic [4:0] reg_addr);
        return {ST_CODE, OP_READ, phy_addr, reg_addr};
    endfunction

endpackage

// File: rtl/mdc_clk_gen.sv
// -----------------------------------------------------------------------------
// mdc_clk_gen
// MDC divider. While en_i is high, mdc_o toggles every CLK_DIV clocks; while
// en_i is low the divider is held with mdc_o low, so each enable starts with a
// full low half-period.
// rise_o / fall_o are single-cycle strobes asserted in the clock cycle whose
// closing edge makes mdc_o rise / fall, so logic acting on a strobe updates on
// the same edge as MDC.
// Ports:
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset
//   en_i    run enable
//   mdc_o   MDIO clock
//   rise_o  strobe: mdc_o rises at the next clock edge
//   fall_o  strobe: mdc_o falls at the next clock edge
// -----------------------------------------------------------------------------
module mdc_clk_gen #(
    parameter int CLK_DIV = 13
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic mdc_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_TERM = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          mdc_q, mdc_d;
    logic          terminal;

    assign terminal = (cnt_q == CNT_TERM);
    assign rise_o   = en_i & terminal & ~mdc_q;
    assign fall_o   = en_i & terminal &  mdc_q;
    assign mdc_o    = mdc_q;

    always_comb begin
        cnt_d = cnt_q;
        mdc_d = mdc_q;
        if (!en_i) begin
            cnt_d = '0;
            mdc_d = 1'b0;
        end else if (terminal) begin
            cnt_d = '0;
            mdc_d = ~mdc_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            mdc_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            mdc_q <= mdc_d;
        end
    end

endmodule

// File: rtl/phy_speed_monitor.sv
// -----------------------------------------------------------------------------
// phy_speed_monitor
// Autonomous MDIO master: every POLL_CYCLES clocks it reads the PHY-specific
// status register and turns the resolved speed/link into the MAC set_1000 /
// set_10 inputs and a link_up LED signal. mdio_oen is active-low (0 = drive).
//
// Ports:
//   clk_50_max10  in   system clock
//   fpga_resetn   in   asynchronous active-low reset
//   phy_resetn    in   low = PHY in reset; poller idles and clears status
//   bus_hold      in   high = do not start a new frame (checked only when the
//                      poll timer has expired)
//   mdio_in       in   MDIO pad input (asynchronous, synchronised here)
//   mdc           out  MDIO clock, runs only while a frame is in progress
//   mdio_out      out  MDIO drive value
//   mdio_oen      out  0 = drive mdio_out, 1 = release
//   set_1000      out  MAC gigabit select
//   set_10        out  MAC 10Mb select
//   link_up       out  PHY real-time link
//   status_valid  out  a resolved status has been decoded
//   poll_busy     out  high from preamble start to the end of the decode cycle
//
// Build option PHY_SPEED_MON_DEBUG_EN adds:
//   status_raw[15:0]  last status word read (loaded at every decode)
//   frame_cnt[7:0]    completed frames, wraps
// -----------------------------------------------------------------------------
module phy_speed_monitor
    import phy_mgmt_pkg::*;
#(
    parameter int         CLK_DIV     = 13,
    parameter logic [4:0] PHY_ADDR    = 5'h00,
    parameter logic [4:0] STAT_REG    = 5'h11,
    parameter int         POLL_CYCLES = 5_000_000
) (
    input  logic        clk_50_max10,
    input  logic        fpga_resetn,
    input  logic        phy_resetn,
    input  logic        bus_hold,
    input  logic        mdio_in,
    output logic        mdc,
    output logic        mdio_out,
    output logic        mdio_oen,
    output logic        set_1000,
    output logic        set_10,
    output logic        link_up,
    output logic        status_valid,
    output logic        poll_busy
`ifdef PHY_SPEED_MON_DEBUG_EN
    ,
    output logic [15:0] status_raw,
    output logic [7:0]  frame_cnt
`endif
);

    localparam int TW = $clog2(POLL_CYCLES + 1);
    localparam logic [TW-1:0]       TIMER_TERM = TW'(POLL_CYCLES - 1);
    localparam logic [CMD_BITS-1:0] CMD_WORD   = read_cmd(PHY_ADDR, STAT_REG);

    mgmt_state_e           state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [5:0]            bit_cnt_q, bit_cnt_d;
    logic [CMD_BITS-1:0]   tx_q, tx_d;
    logic [DATA_BITS-1:0]  rx_q, rx_d;
    logic                  mdio_out_q, mdio_out_d;
    logic                  mdio_oen_q, mdio_oen_d;
    logic                  set_1000_q, set_1000_d;
    logic                  set_10_q, set_10_d;
    logic                  link_up_q, link_up_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  mdio_meta_q, mdio_sync_q;
`ifdef PHY_SPEED_MON_DEBUG_EN
    logic [15:0]           status_raw_q, status_raw_d;
    logic [7:0]            frame_cnt_q, frame_cnt_d;
`endif

    logic mdc_en, mdc_rise, mdc_fall;

    // Divider is stopped in DONE so MDC is low there, and drops combinationally
    // with phy_resetn so MDC is low on the very next clock after a PHY reset.
    assign mdc_en = busy_q & (state_q != DONE) & phy_resetn;

    mdc_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_mdc (
        .clk_i  (clk_50_max10),
        .rst_ni (fpga_resetn),
        .en_i   (mdc_en),
        .mdc_o  (mdc),
        .rise_o (mdc_rise),
        .fall_o (mdc_fall)
    );

    always_ff @(posedge clk_50_max10 or negedge fpga_resetn) begin
        if (!fpga_resetn) begin
            mdio_meta_q <= 1'b1;
            mdio_sync_q <= 1'b1;
        end else begin
            mdio_meta_q <= mdio_in;
            mdio_sync_q <= mdio_meta_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        bit_cnt_d  = bit_cnt_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        mdio_out_d = mdio_out_q;
        mdio_oen_d = mdio_oen_q;
        set_1000_d = set_1000_q;
        set_10_d   = set_10_q;
        link_up_d  = link_up_q;
        valid_d    = valid_q;
`ifdef PHY_SPEED_MON_DEBUG_EN
        status_raw_d = status_raw_q;
        frame_cnt_d  = frame_cnt_q;
`endif

        if (!phy_resetn) begin
            // PHY reset overrides everything: drop any partial frame.
            state_d    = IDLE;
            timer_d    = '0;
            bit_cnt_d  = '0;
            mdio_out_d = 1'b1;
            mdio_oen_d = 1'b1;
            set_1000_d = 1'b0;
            set_10_d   = 1'b0;
            link_up_d  = 1'b0;
            valid_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = WAIT;
                    timer_d = '0;
                end
                WAIT: begin
                    // Timer parks at terminal count while the bus is held.
                    if (timer_q == TIMER_TERM) begin
                        if (!bus_hold) begin
                            state_d    = PRE;
                            bit_cnt_d  = '0;
                            mdio_out_d = 1'b1;
                            mdio_oen_d = 1'b0;
                        end
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                PRE: begin
                    if (mdc_fall) begin
                        if (bit_cnt_q == 6'(PRE_BITS - 1)) begin
                            state_d    = CMD;
                            bit_cnt_d  = '0;
                            mdio_out_d = CMD_WORD[CMD_BITS-1];
                            tx_d       = CMD_WORD << 1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
                CMD: begin
                    if (mdc_fall) begin
                        if (bit_cnt_q == 6'(CMD_BITS - 1)) begin
                            state_d    = TA;
                            bit_cnt_d  = '0;
                            mdio_out_d = 1'b1;
                            mdio_oen_d = 1'b1;
                        end else begin
                            bit_cnt_d  = bit_cnt_q + 1'b1;
                            mdio_out_d = tx_q[CMD_BITS-1];
                            tx_d       = {tx_q[CMD_BITS-2:0], 1'b0};
                        end
                    end
                end
                TA: begin
                    if (mdc_fall) begin
                        if (bit_cnt_q == 6'(TA_BITS - 1)) begin
                            state_d   = DATA;
                            bit_cnt_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (mdc_rise) begin
                        rx_d = {rx_q[DATA_BITS-2:0], mdio_sync_q};
                    end
                    // The last bit is sampled on the rise before this fall.
                    if (mdc_fall) begin
                        if (bit_cnt_q == 6'(DATA_BITS - 1)) begin
                            state_d   = DONE;
                            bit_cnt_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_d = WAIT;
                    timer_d = '0;
                    if (rx_q[STAT_RESOLVED]) begin
                        valid_d = 1'b1;
                        if (!rx_q[STAT_LINK]) begin
                            link_up_d  = 1'b0;
                            set_1000_d = 1'b0;
                            set_10_d   = 1'b0;
                        end else begin
                            link_up_d = 1'b1;
                            case (rx_q[STAT_SPD_HI:STAT_SPD_LO])
                                SPD_1000: begin
                                    set_1000_d = 1'b1;
                                    set_10_d   = 1'b0;
                                end
                                SPD_100: begin
                                    set_1000_d = 1'b0;
                                    set_10_d   = 1'b0;
                                end
                                SPD_10: begin
                                    set_1000_d = 1'b0;
                                    set_10_d   = 1'b1;
                                end
                                default: ; // reserved code: keep current speed
                            endcase
                        end
                    end
`ifdef PHY_SPEED_MON_DEBUG_EN
                    status_raw_d = rx_q;
                    frame_cnt_d  = frame_cnt_q + 1'b1;
`endif
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d == PRE) || (state_d == CMD) || (state_d == TA) ||
                 (state_d == DATA) || (state_d == DONE);
    end

    always_ff @(posedge clk_50_max10 or negedge fpga_resetn) begin
        if (!fpga_resetn) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            bit_cnt_q  <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            mdio_out_q <= 1'b1;
            mdio_oen_q <= 1'b1;
            set_1000_q <= 1'b0;
            set_10_q   <= 1'b0;
            link_up_q  <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            mdio_out_q <= mdio_out_d;
            mdio_oen_q <= mdio_oen_d;
            set_1000_q <= set_1000_d;
            set_10_q   <= set_10_d;
            link_up_q  <= link_up_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
        end
    end

`ifdef PHY_SPEED_MON_DEBUG_EN
    always_ff @(posedge clk_50_max10 or negedge fpga_resetn) begin
        if (!fpga_resetn) begin
            status_raw_q <= '0;
            frame_cnt_q  <= '0;
        end else begin
            status_raw_q <= status_raw_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign status_raw = status_raw_q;
    assign frame_cnt  = frame_cnt_q;
`endif

    assign mdio_out     = mdio_out_q;
    assign mdio_oen     = mdio_oen_q;
    assign set_1000     = set_1000_q;
    assign set_10       = set_10_q;
    assign link_up      = link_up_q;
    assign status_valid = valid_q;
    assign poll_busy    = busy_q;

endmodule

// File: tb/tb_phy_speed_monitor.sv
// -----------------------------------------------------------------------------
// tb_phy_speed_monitor
// A PHY model answers each read frame with a status word (directed list first,
// then random). At frame start the expected decoded outputs are computed from
// the status-decode rules and queued; a separate monitor pops and compares
// when the frame ends, together with the captured MDIO bitstream and timing.
// -----------------------------------------------------------------------------
module tb_phy_speed_monitor;

    localparam int CLK_DIV     = 2;
    localparam int POLL_CYCLES = 100;
    localparam int FRAME_CLKS  = 64 * 2 * CLK_DIV;

    logic clk = 1'b0;
    logic fpga_resetn, phy_resetn, bus_hold, mdio_in;
    logic mdc, mdio_out, mdio_oen, set_1000, set_10, link_up, status_valid, poll_busy;
`ifdef PHY_SPEED_MON_DEBUG_EN
    logic [15:0] status_raw;
    logic [7:0]  frame_cnt;
`endif

    always #5 clk = ~clk;

    phy_speed_monitor #(
        .CLK_DIV     (CLK_DIV),
        .PHY_ADDR    (5'h00),
        .STAT_REG    (5'h11),
        .POLL_CYCLES (POLL_CYCLES)
    ) dut (
        .clk_50_max10 (clk),
        .fpga_resetn  (fpga_resetn),
        .phy_resetn   (phy_resetn),
        .bus_hold     (bus_hold),
        .mdio_in      (mdio_in),
        .mdc          (mdc),
        .mdio_out     (mdio_out),
        .mdio_oen     (mdio_oen),
        .set_1000     (set_1000),
        .set_10       (set_10),
        .link_up      (link_up),
        .status_valid (status_valid),
        .poll_busy    (poll_busy)
`ifdef PHY_SPEED_MON_DEBUG_EN
        ,
        .status_raw   (status_raw),
        .frame_cnt    (frame_cnt)
`endif
    );

    typedef struct {
        logic [15:0] word;
        logic [3:0]  st;   // {status_valid, link_up, set_1000, set_10}
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    logic [15:0] stim_q[$];
    exp_t        exp_q[$];

    // reference state of the decoded outputs
    logic ref_valid = 0, ref_link = 0, ref_1000 = 0, ref_10 = 0;

    // PHY model / capture state
    int          rise_cnt = 0;
    int          busy_len = 0;
    logic [15:0] cur_word = '0;
    logic [63:0] cap_out = '0, cap_oen = '0;
    logic        a_busy_prev = 0, a_mdc_prev = 0, m_busy_prev = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d..%0d", name, act, lo, hi);
        end
    endtask

    // Status decode rules applied to the reference outputs.
    function automatic logic [3:0] ref_apply(input logic [15:0] s);
        if (s[11]) begin
            ref_valid = 1'b1;
            if (!s[10]) begin
                ref_link = 1'b0; ref_1000 = 1'b0; ref_10 = 1'b0;
            end else begin
                ref_link = 1'b1;
                if (s[15:14] == 2'b10)      begin ref_1000 = 1'b1; ref_10 = 1'b0; end
                else if (s[15:14] == 2'b01) begin ref_1000 = 1'b0; ref_10 = 1'b0; end
                else if (s[15:14] == 2'b00) begin ref_1000 = 1'b0; ref_10 = 1'b1; end
            end
        end
        return {ref_valid, ref_link, ref_1000, ref_10};
    endfunction

    // Expected master bitstream: 32 ones, then ST OP PHYAD REGAD; driven for 46 periods.
    function automatic logic [63:0] exp_stream();
        logic [13:0] cmd;
        logic [63:0] v;
        cmd = {2'b01, 2'b10, 5'h00, 5'h11};
        v = '0;
        for (int i = 0; i < 46; i++) v[i] = (i < 32) ? 1'b1 : cmd[13 - (i - 32)];
        return v;
    endfunction

    // PHY model: pushes expectations at frame start, drives read data after MDC rises.
    always @(negedge clk) begin
        if (poll_busy && !a_busy_prev) begin
            rise_cnt = 0;
            busy_len = 0;
            cap_out  = '0;
            cap_oen  = '0;
            if (stim_q.size() > 0) cur_word = stim_q.pop_front();
            else begin
                cur_word = 16'($urandom);
                if ($urandom_range(0, 3) != 0) cur_word[11] = 1'b1;
            end
            exp_q.push_back('{word: cur_word, st: ref_apply(cur_word)});
        end
        if (poll_busy) busy_len++;
        if (mdc && !a_mdc_prev) begin
            if (rise_cnt < 64) begin
                cap_out[rise_cnt] = mdio_out;
                cap_oen[rise_cnt] = mdio_oen;
            end
            rise_cnt++;
            // bit for rise r+1 is presented right after rise r (rises 49..64 carry DATA)
            if (rise_cnt >= 48 && rise_cnt <= 63) mdio_in = cur_word[63 - rise_cnt];
            else mdio_in = 1'b1;
        end
        if (!poll_busy && a_busy_prev) mdio_in = 1'b1;
        a_busy_prev = poll_busy;
        a_mdc_prev  = mdc;
    end

    // Monitor: compares at the end of each frame.
    always @(negedge clk) begin
        exp_t e;
        if (!poll_busy && m_busy_prev) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty actual=0 expected=1");
            end else begin
                e = exp_q.pop_front();
                if (!phy_resetn) begin
                    $display("frame aborted word=%h rises=%0d (expectation dropped)", e.word, rise_cnt);
                end else begin
                    done_cnt++;
                    check("status_out", {status_valid, link_up, set_1000, set_10}, e.st);
                    check("mdc_rises", rise_cnt, 64);
                    check("busy_len", busy_len, FRAME_CLKS + 1);
                    check("stream_out", cap_out & 64'h3FFF_FFFF_FFFF, exp_stream());
                    check("stream_oen", cap_oen, 64'hFFFF_C000_0000_0000);
`ifdef PHY_SPEED_MON_DEBUG_EN
                    check("status_raw", status_raw, e.word);
                    check("frame_cnt", frame_cnt, done_cnt % 256);
`endif
                    $display("frame %0d word=%h valid=%0b link=%0b s1000=%0b s10=%0b",
                             done_cnt, e.word, status_valid, link_up, set_1000, set_10);
                end
            end
        end
        m_busy_prev = poll_busy;
    end

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 2000 * target) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL wait_done actual=%0d expected=%0d", done_cnt, target);
        end
    endtask

    task automatic wait_rise(input int r);
        int n = 0;
        while (!(poll_busy && rise_cnt >= r) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!(poll_busy && rise_cnt >= r)) begin
            checks++;
            errors++;
            $display("FAIL wait_rise actual=%0d expected=%0d", rise_cnt, r);
        end
    endtask

    task automatic measure_first_pre(input string name);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!poll_busy && n < 300);
        check_range(name, n, POLL_CYCLES, POLL_CYCLES + 2);
    endtask

    initial begin
        int cnt;
        fpga_resetn = 1'b0;
        phy_resetn  = 1'b1;
        bus_hold    = 1'b0;
        mdio_in     = 1'b1;
        stim_q = '{16'hAC00, 16'h4C00, 16'h0C00, 16'h0800, 16'hA400, 16'hEC00};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mdc", mdc, 0);
        check("rst_mdio_out", mdio_out, 1);
        check("rst_mdio_oen", mdio_oen, 1);
        check("rst_set_1000", set_1000, 0);
        check("rst_set_10", set_10, 0);
        check("rst_link_up", link_up, 0);
        check("rst_status_valid", status_valid, 0);
        check("rst_poll_busy", poll_busy, 0);

        @(posedge clk);
        #1 fpga_resetn = 1'b1;
        measure_first_pre("first_pre_delay");

        // directed decode sequence
        wait_done(6);

        // bus_hold parks the poller at terminal count
        bus_hold = 1'b1;
        cnt = 0;
        repeat (POLL_CYCLES + 500) begin
            @(posedge clk);
            #1;
            if (mdc || poll_busy) cnt++;
        end
        check("hold_no_activity", cnt, 0);
        bus_hold = 1'b0;
        @(posedge clk);
        #1 check("hold_release_pre", poll_busy, 1);

        // bus_hold during DATA does not disturb the frame
        wait_rise(50);
        bus_hold = 1'b1;
        wait_done(7);
        bus_hold = 1'b0;

        // PHY reset mid-DATA aborts the frame and clears status
        wait_rise(52);
        @(posedge clk);
        #1 phy_resetn = 1'b0;
        ref_valid = 1'b0; ref_link = 1'b0; ref_1000 = 1'b0; ref_10 = 1'b0;
        @(posedge clk);
        #1;
        check("abort_mdc", mdc, 0);
        check("abort_oen", mdio_oen, 1);
        check("abort_mdio_out", mdio_out, 1);
        check("abort_busy", poll_busy, 0);
        check("abort_status", {status_valid, link_up, set_1000, set_10}, 4'b0000);
        repeat (5) @(posedge clk);
        #1 phy_resetn = 1'b1;
        measure_first_pre("repoll_delay");

        // random status words
        wait_done(19);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
